fetch_unit: RTL and testbench

Instruction-fetch stage sitting directly downstream of the PC latch. It consumes the latched PC, issues one instruction-memory read at a time over a valid/ready request channel, and collects the response. It presents a registered instruction/PC bundle to the IF/ID boundary. It also drives the PC latch's advance enable, handles decode-stage stalls with a one-entry skid buffer, and discards wrong-path responses on branch/jump redirect (flush).

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_skid_buffer.sv | 24 ++
 rtl/fetch_unit.sv | 90 +++++++++
 tb/tb_fetch_unit.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: IF-stage state encoding, NOP default and IF/ID bundle field widths shared with decode
package fetch_pkg;
    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INSTR_DEF = 32'h0000_0000;
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_e;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: one-entry {pc, instr} holding register with load/clear/valid
module fetch_skid_buffer
    import fetch_pkg::*;
(
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic         i_clear,
    input  fetch_entry_t i_entry,
    output logic         o_valid,
    output fetch_entry_t o_entry
);
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            o_valid <= 1'b0;
            o_entry <= '0;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_entry <= i_entry;
        end else if (i_clear) begin
            o_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with skid buffer, flush drain and misalign trap
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ILEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic [XLEN-1:0] i_pc_in,
    output logic            o_pc_enable,
    input  logic            i_flush,
    input  logic            i_stall,
    output logic            o_imem_req_valid,
    output logic [XLEN-1:0] o_imem_req_addr,
    input  logic            i_imem_req_ready,
    input  logic            i_imem_resp_valid,
    input  logic [ILEN-1:0] i_imem_resp_data,
    output logic            o_if_valid,
    output logic [ILEN-1:0] o_if_instr,
    output logic [XLEN-1:0] o_if_pc,
    output logic [XLEN-1:0] o_if_pc_plus4,
    output logic            o_if_exc_misalign
);
    fetch_state_e    r_state;
    logic [XLEN-1:0] r_req_pc;
    logic            w_aligned, w_slot_free, w_fire;
    logic            w_misalign_wr, w_resp_wr, w_skid_wr, w_skid_load, w_wr;
    logic            w_skid_valid;
    fetch_entry_t    w_skid_entry, w_wr_entry;

    assign w_aligned        = i_pc_in[1:0] == 2'b00;
    assign w_slot_free      = !o_if_valid || !i_stall;
    assign o_imem_req_addr  = i_pc_in;
    assign o_imem_req_valid = i_reset && r_state == S_REQ && !i_flush && w_aligned;
    assign w_fire           = o_imem_req_valid && i_imem_req_ready;
    assign o_pc_enable      = i_reset && (i_flush || w_fire);

    // At most one of these can be set: each is tied to a distinct state
    assign w_misalign_wr = r_state == S_REQ && !w_aligned && w_slot_free;
    assign w_resp_wr     = r_state == S_WAIT && i_imem_resp_valid && w_slot_free;
    assign w_skid_wr     = r_state == S_HOLD && w_skid_valid && !i_stall;
    assign w_skid_load   = r_state == S_WAIT && i_imem_resp_valid && !w_slot_free && !i_flush;
    assign w_wr          = !i_flush && (w_misalign_wr || w_resp_wr || w_skid_wr);
    assign w_wr_entry    = w_skid_wr ? w_skid_entry :
                           w_resp_wr ? {r_req_pc, i_imem_resp_data} : {i_pc_in, NOP_INSTR};

    fetch_skid_buffer u_skid (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_load  (w_skid_load),
        .i_clear (i_flush || w_skid_wr),
        .i_entry ({r_req_pc, i_imem_resp_data}),
        .o_valid (w_skid_valid),
        .o_entry (w_skid_entry)
    );

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state           <= S_REQ;
            r_req_pc          <= '0;
            o_if_valid        <= 1'b0;
            o_if_instr        <= NOP_INSTR;
            o_if_pc           <= '0;
            o_if_pc_plus4     <= 32'd4;
            o_if_exc_misalign <= 1'b0;
        end else begin
            if (w_fire)
                r_req_pc <= i_pc_in;
            if (i_flush) begin
                o_if_valid        <= 1'b0;
                o_if_exc_misalign <= 1'b0;
                o_if_instr        <= NOP_INSTR;
            end else if (w_wr) begin
                o_if_valid        <= 1'b1;
                o_if_instr        <= w_wr_entry.instr;
                o_if_pc           <= w_wr_entry.pc;
                o_if_pc_plus4     <= w_wr_entry.pc + 32'd4;
                o_if_exc_misalign <= w_misalign_wr;
            end else if (!i_stall) begin
                o_if_valid <= 1'b0;
            end
            // A flushed DRAIN that also sees the late response has nothing left in flight
            r_state <= (r_state == S_REQ)  ? (w_fire ? S_WAIT : S_REQ) :
                       (r_state == S_WAIT) ? (i_imem_resp_valid ? ((i_flush || w_slot_free) ? S_REQ : S_HOLD)
                                                                : (i_flush ? S_DRAIN : S_WAIT)) :
                       (r_state == S_HOLD) ? ((i_flush || !i_stall) ? S_REQ : S_HOLD) :
                                             (i_imem_resp_valid ? S_REQ : S_DRAIN);
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plan plus random traffic scored against an in-order fetch queue model
module tb_fetch_unit;
    import fetch_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_in = '0;
    logic [31:0] pc_next = '0;
    logic [31:0] tgt = '0;
    logic        flush = 1'b0, stall = 1'b0, ready = 1'b0;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_data = '0;
    logic        pc_en, req_valid, if_valid, if_exc;
    logic [31:0] req_addr, if_instr, if_pc, if_pc_plus4;

    int          total = 0, bad = 0, en_cnt = 0, lat = 1, cnt = 0;
    bit          sb_en = 1'b0, rand_lat = 1'b0, fire_seen = 1'b0, rst_seen = 1'b0;
    logic [31:0] fire_addr = '0, raddr = '0;
    exp_t        q[$];
    exp_t        e;

    always #5 clk = ~clk;

    fetch_unit dut (
        .i_clock           (clk),
        .i_reset           (rst_n),
        .i_pc_in           (pc_in),
        .o_pc_enable       (pc_en),
        .i_flush           (flush),
        .i_stall           (stall),
        .o_imem_req_valid  (req_valid),
        .o_imem_req_addr   (req_addr),
        .i_imem_req_ready  (ready),
        .i_imem_resp_valid (resp_valid),
        .i_imem_resp_data  (resp_data),
        .o_if_valid        (if_valid),
        .o_if_instr        (if_instr),
        .o_if_pc           (if_pc),
        .o_if_pc_plus4     (if_pc_plus4),
        .o_if_exc_misalign (if_exc)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a == 32'h0040_0000 ? 32'h2008_0005 :
               a == 32'h0000_1000 ? 32'hDEAD_BEEF : (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Sample the pre-edge picture: PC latch model, fire detection and in-order scoreboard
    always @(negedge clk) begin
        rst_seen  = rst_n;
        fire_seen = rst_n && req_valid && ready;
        fire_addr = req_addr;
        en_cnt    += int'(pc_en);
        pc_next   = (!rst_n || flush) ? tgt : pc_en ? pc_in + 32'd4 : pc_in;
        if (!rst_n || !sb_en || flush) q.delete();
        else if (if_valid && !stall) begin
            chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sb_pc", if_pc, e.pc);
                chk("sb_instr", if_instr, e.instr);
                chk("sb_plus4", if_pc_plus4, e.pc + 32'd4);
                chk("sb_exc", 32'(if_exc), 32'd0);
            end
        end
        if (sb_en && fire_seen) q.push_back('{pc: req_addr, instr: mem(req_addr)});
    end

    always @(posedge clk) pc_in <= pc_next;

    // Memory: one response k cycles after each accepted request
    always @(posedge clk) begin
        #1;
        resp_valid = 1'b0;
        if (!rst_seen) cnt = 0;
        else begin
            if (fire_seen) begin
                cnt   = rand_lat ? int'($urandom_range(1, 3)) : lat;
                raddr = fire_addr;
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    resp_valid = 1'b1;
                    resp_data  = mem(raddr);
                end
            end
        end
    end

    initial begin
        tgt   = 32'h0040_0000;
        ready = 1'b1;
        nxt();
        @(negedge clk);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_plus4", if_pc_plus4, 32'd4);
        chk("rst_exc", 32'(if_exc), 32'd0);
        chk("rst_reqv", 32'(req_valid), 32'd0);
        chk("rst_pcen", 32'(pc_en), 32'd0);
        nxt();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_reqv", 32'(req_valid), 32'd1);
        chk("post_rst_addr", req_addr, 32'h0040_0000);
        nxt();
        nxt();
        @(negedge clk);
        chk("first_valid", 32'(if_valid), 32'd1);
        chk("first_pc", if_pc, 32'h0040_0000);
        chk("first_plus4", if_pc_plus4, 32'h0040_0004);
        chk("first_instr", if_instr, 32'h2008_0005);

        nxt();
        ready = 1'b0;
        flush = 1'b1;
        tgt   = 32'h0;
        nxt();
        flush = 1'b0;
        repeat (3) nxt();
        sb_en  = 1'b1;
        en_cnt = 0;
        ready  = 1'b1;
        nxt();
        for (int i = 0; i < 3; i++) begin
            nxt();
            if (i == 2) ready = 1'b0;
            @(negedge clk);
            chk("b2b_valid", 32'(if_valid), 32'd1);
            chk("b2b_pc", if_pc, 32'(4 * i));
            nxt();
            @(negedge clk);
            chk("b2b_gap", 32'(if_valid), 32'd0);
        end
        chk("b2b_pcen_cnt", 32'(en_cnt), 32'd3);

        nxt();
        ready = 1'b1;
        nxt();
        nxt();
        stall = 1'b1;
        nxt();
        ready = 1'b0;
        nxt();
        @(negedge clk);
        chk("skid_state", 32'(dut.r_state), 32'(S_HOLD));
        chk("skid_hold_pc", if_pc, 32'h0000_000C);
        chk("skid_hold_valid", 32'(if_valid), 32'd1);
        chk("skid_no_req", 32'(req_valid), 32'd0);
        nxt();
        @(negedge clk);
        chk("skid_hold_pc2", if_pc, 32'h0000_000C);
        nxt();
        stall = 1'b0;
        nxt();
        @(negedge clk);
        chk("skid_out_valid", 32'(if_valid), 32'd1);
        chk("skid_out_pc", if_pc, 32'h0000_0010);
        chk("skid_out_instr", if_instr, mem(32'h0000_0010));

        nxt();
        flush = 1'b1;
        tgt   = 32'h0000_1000;
        nxt();
        flush = 1'b0;
        nxt();
        lat   = 2;
        ready = 1'b1;
        nxt();
        ready = 1'b0;
        flush = 1'b1;
        tgt   = 32'h0000_2000;
        nxt();
        flush = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        chk("drain_state", 32'(dut.r_state), 32'(S_DRAIN));
        nxt();
        @(negedge clk);
        chk("drain_done", 32'(dut.r_state), 32'(S_REQ));
        chk("drain_valid", 32'(if_valid), 32'd0);
        chk("drain_instr", if_instr, 32'h0);
        chk("redir_reqv", 32'(req_valid), 32'd1);
        chk("redir_addr", req_addr, 32'h0000_2000);
        nxt();
        ready = 1'b0;
        nxt();
        nxt();
        @(negedge clk);
        chk("redir_pc", if_pc, 32'h0000_2000);
        chk("redir_instr", if_instr, mem(32'h0000_2000));

        lat = 1;
        nxt();
        flush = 1'b1;
        tgt   = 32'h0000_1000;
        nxt();
        flush = 1'b0;
        nxt();
        ready = 1'b1;
        nxt();
        ready = 1'b0;
        flush = 1'b1;
        tgt   = 32'h0000_3000;
        nxt();
        flush = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        chk("coinc_state", 32'(dut.r_state), 32'(S_REQ));
        chk("coinc_valid", 32'(if_valid), 32'd0);
        chk("coinc_addr", req_addr, 32'h0000_3000);
        nxt();
        ready = 1'b0;
        nxt();
        @(negedge clk);
        chk("coinc_pc", if_pc, 32'h0000_3000);
        chk("coinc_instr", if_instr, mem(32'h0000_3000));

        sb_en = 1'b0;
        ready = 1'b1;
        flush = 1'b1;
        tgt   = 32'h0000_0006;
        nxt();
        flush = 1'b0;
        @(negedge clk);
        chk("mis_reqv", 32'(req_valid), 32'd0);
        chk("mis_pcen", 32'(pc_en), 32'd0);
        nxt();
        @(negedge clk);
        chk("mis_valid", 32'(if_valid), 32'd1);
        chk("mis_exc", 32'(if_exc), 32'd1);
        chk("mis_instr", if_instr, 32'h0);
        chk("mis_pc", if_pc, 32'h0000_0006);
        chk("mis_plus4", if_pc_plus4, 32'h0000_000A);
        for (int i = 0; i < 4; i++) begin
            stall = 1'($urandom % 2);
            nxt();
            @(negedge clk);
            chk("mis_hold_exc", 32'(if_exc), 32'd1);
            chk("mis_hold_pc", if_pc, 32'h0000_0006);
        end
        stall = 1'b0;
        flush = 1'b1;
        tgt   = 32'hFFFF_FFFC;
        nxt();
        flush = 1'b0;
        sb_en = 1'b1;
        @(negedge clk);
        chk("mis_clr_valid", 32'(if_valid), 32'd0);
        chk("mis_clr_exc", 32'(if_exc), 32'd0);
        chk("wrap_addr", req_addr, 32'hFFFF_FFFC);
        nxt();
        nxt();
        @(negedge clk);
        chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", if_pc_plus4, 32'h0000_0000);

        rand_lat = 1'b1;
        for (int i = 0; i < 800; i++) begin
            stall = ($urandom % 4) == 0;
            ready = ($urandom % 3) != 0;
            flush = ($urandom % 20) == 0;
            tgt   = $urandom & 32'h0000_FFFC;
            nxt();
        end
        stall = 1'b0;
        flush = 1'b0;
        ready = 1'b0;
        for (int i = 0; i < 40 && (q.size() != 0 || if_valid); i++) nxt();
        chk("sb_drained", 32'(q.size()), 32'd0);
        chk("final_valid", 32'(if_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
